// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and helpers for the operand forwarding stage.
//   SEL_RF          select code meaning "take register file data"
//   *_DEF           default widths/counts for fwd_operand_stage and fwd_select
//   CNT_W           width of the optional statistics counters
//   sel_width()     select code width for a given number of bypass sources
//   sat_add()       saturating counter add used by the statistics logic
package fwd_pkg;

    localparam int SEL_RF      = 0;
    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int NUM_SRC_DEF = 3;
    localparam int NUM_OPS_DEF = 2;
    localparam int CNT_W       = 32;

    // One code per bypass source plus the register file code.
    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [CNT_W-1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: combinational bypass priority select for a single operand.
//   rs_addr    source register address of this operand
//   rf_data    register file read data for this operand
//   byp_addr   destination address per bypass source (source 0 youngest)
//   byp_wen    bypass source will write its destination
//   byp_ready  bypass data is available (0 = load still in flight)
//   byp_data   bypass data per source
//   data       selected operand value
//   sel        select code: SEL_RF or k for source k-1
//   not_ready  the winning source has no data yet
module fwd_select
    import fwd_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int NUM_SRC = NUM_SRC_DEF,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_SRC*ADDR_W-1:0] byp_addr,
    input  logic [NUM_SRC-1:0]        byp_wen,
    input  logic [NUM_SRC-1:0]        byp_ready,
    input  logic [NUM_SRC*DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0]         data,
    output logic [SEL_W-1:0]          sel,
    output logic                      not_ready
);

    always_comb begin
        data      = rf_data;
        sel       = SEL_W'(SEL_RF);
        not_ready = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites. The
        // winner is final even if it is not ready: an older source holds
        // stale data for this register and must not be used as a fallback.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (byp_wen[i] && (rs_addr != '0) &&
                (byp_addr[i*ADDR_W +: ADDR_W] == rs_addr)) begin
                data      = byp_data[i*DATA_W +: DATA_W];
                sel       = SEL_W'(i + 1);
                not_ready = ~byp_ready[i];
            end
        end
    end

endmodule

// File: rtl/fwd_operand_stage.sv
// fwd_operand_stage: per-operand bypass selection plus the ID/EX register.
// Sits between the register file read and the EX stage.
//   clk_i, rst_i       clock (rising edge), synchronous active-low reset
//   stall_i, flush_i   hold / kill the registered instruction (flush wins)
//   valid_i            incoming instruction valid
//   rs_addr_i, rf_data_i              per-operand source address and RF data
//   byp_addr_i, byp_wen_i, byp_ready_i, byp_data_i   per-source bypass info
//   hazard_o           combinational load-use hazard; upstream must hold
//   valid_o, op_data_o, sel_o         registered instruction valid/operands/selects
// Build option FWD_STATS_EN adds fwd_cnt_o (per-source forwarding hits) and
// bubble_cnt_o (load-use bubbles), both saturating, cleared only by reset.
module fwd_operand_stage
    import fwd_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int NUM_SRC = NUM_SRC_DEF,
    parameter  int NUM_OPS = NUM_OPS_DEF,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      valid_i,
    input  logic [NUM_OPS*ADDR_W-1:0] rs_addr_i,
    input  logic [NUM_OPS*DATA_W-1:0] rf_data_i,
    input  logic [NUM_SRC*ADDR_W-1:0] byp_addr_i,
    input  logic [NUM_SRC-1:0]        byp_wen_i,
    input  logic [NUM_SRC-1:0]        byp_ready_i,
    input  logic [NUM_SRC*DATA_W-1:0] byp_data_i,
    output logic                      hazard_o,
    output logic                      valid_o,
    output logic [NUM_OPS*DATA_W-1:0] op_data_o,
    output logic [NUM_OPS*SEL_W-1:0]  sel_o
`ifdef FWD_STATS_EN
    ,
    output logic [NUM_SRC*CNT_W-1:0]  fwd_cnt_o,
    output logic [CNT_W-1:0]          bubble_cnt_o
`endif
);

    logic [NUM_OPS*DATA_W-1:0] sel_data;
    logic [NUM_OPS*SEL_W-1:0]  sel_code;
    logic [NUM_OPS-1:0]        op_not_ready;

    for (genvar j = 0; j < NUM_OPS; j++) begin : g_op
        fwd_select #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_SRC (NUM_SRC)
        ) u_sel (
            .rs_addr   (rs_addr_i[j*ADDR_W +: ADDR_W]),
            .rf_data   (rf_data_i[j*DATA_W +: DATA_W]),
            .byp_addr  (byp_addr_i),
            .byp_wen   (byp_wen_i),
            .byp_ready (byp_ready_i),
            .byp_data  (byp_data_i),
            .data      (sel_data[j*DATA_W +: DATA_W]),
            .sel       (sel_code[j*SEL_W +: SEL_W]),
            .not_ready (op_not_ready[j])
        );
    end

    // Driven regardless of stall so upstream always sees the dependency.
    assign hazard_o = valid_i && (|op_not_ready);

    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            valid_o   <= 1'b0;
            op_data_o <= '0;
            sel_o     <= '0;
        end else if (!stall_i) begin
            if (hazard_o) begin
                // Bubble: upstream re-presents the same instruction next cycle.
                valid_o   <= 1'b0;
                op_data_o <= '0;
                sel_o     <= '0;
            end else begin
                valid_o   <= valid_i;
                op_data_o <= sel_data;
                sel_o     <= sel_code;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [NUM_SRC-1:0][CNT_W-1:0] fwd_cnt_q;
    logic [NUM_SRC-1:0][CNT_W-1:0] fwd_inc;
    logic [CNT_W-1:0]              bubble_cnt_q;
    logic                          capture_hit;
    logic                          bubble_hit;

    assign capture_hit = !flush_i && !stall_i && !hazard_o && valid_i;
    assign bubble_hit  = !flush_i && !stall_i && hazard_o;

    // Number of operands selecting each source this cycle.
    always_comb begin
        fwd_inc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_OPS; j++) begin
                if (sel_code[j*SEL_W +: SEL_W] == SEL_W'(i + 1)) begin
                    fwd_inc[i] = fwd_inc[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fwd_cnt_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (capture_hit) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    fwd_cnt_q[i] <= sat_add(fwd_cnt_q[i], fwd_inc[i]);
                end
            end
            if (bubble_hit) begin
                bubble_cnt_q <= sat_add(bubble_cnt_q, CNT_W'(1));
            end
        end
    end

    assign fwd_cnt_o    = fwd_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_operand_stage.sv
// tb_fwd_operand_stage: directed vectors for fwd_operand_stage with a queue
// of expected register contents and hazard values checked by a monitor.
module tb_fwd_operand_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        flush_i;
    logic        valid_i;
    logic [9:0]  rs_addr_i;
    logic [63:0] rf_data_i;
    logic [14:0] byp_addr_i;
    logic [2:0]  byp_wen_i;
    logic [2:0]  byp_ready_i;
    logic [95:0] byp_data_i;
    logic        hazard_o;
    logic        valid_o;
    logic [63:0] op_data_o;
    logic [3:0]  sel_o;
`ifdef FWD_STATS_EN
    logic [95:0] fwd_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    fwd_operand_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .rs_addr_i   (rs_addr_i),
        .rf_data_i   (rf_data_i),
        .byp_addr_i  (byp_addr_i),
        .byp_wen_i   (byp_wen_i),
        .byp_ready_i (byp_ready_i),
        .byp_data_i  (byp_data_i),
        .hazard_o    (hazard_o),
        .valid_o     (valid_o),
        .op_data_o   (op_data_o),
        .sel_o       (sel_o)
`ifdef FWD_STATS_EN
        ,
        .fwd_cnt_o   (fwd_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          v;
        logic [63:0] d;
        logic [3:0]  s;
        bit          st_chk;
        logic [31:0] f0, f1, f2, b;
    } exp_t;

    exp_t rq[$];
    bit   hq[$];
    int   total  = 0;
    int   passed = 0;
    bit   drv_done = 1'b0;

    bit          st_chk_nxt = 1'b0;
    logic [31:0] st_f0, st_f1, st_f2, st_b;

    function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endfunction

    task automatic vec(input bit rst, v, st, fl,
                       input logic [4:0] r0, r1, input logic [31:0] f0, f1,
                       input logic [4:0] a0, a1, a2, input logic [2:0] wen, rdy,
                       input logic [31:0] d0, d1, d2, input bit hz, ev,
                       input logic [31:0] e0, e1, input logic [1:0] s0, s1);
        exp_t e;
        @(negedge clk_i);
        #1;
        rst_i       = rst;
        valid_i     = v;
        stall_i     = st;
        flush_i     = fl;
        rs_addr_i   = {r1, r0};
        rf_data_i   = {f1, f0};
        byp_addr_i  = {a2, a1, a0};
        byp_wen_i   = wen;
        byp_ready_i = rdy;
        byp_data_i  = {d2, d1, d0};
        hq.push_back(hz);
        e.v = ev; e.d = {e1, e0}; e.s = {s1, s0};
        e.st_chk = st_chk_nxt; e.f0 = st_f0; e.f1 = st_f1; e.f2 = st_f2; e.b = st_b;
        rq.push_back(e);
        st_chk_nxt = 1'b0;
    endtask

    task automatic expect_stats(input logic [31:0] f0, f1, f2, b);
        st_chk_nxt = 1'b1; st_f0 = f0; st_f1 = f1; st_f2 = f2; st_b = b;
    endtask

    // Driver
    initial begin
        rst_i = 1'b0; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        rs_addr_i = '0; rf_data_i = '0; byp_addr_i = '0;
        byp_wen_i = '0; byp_ready_i = '0; byp_data_i = '0;
        st_f0 = '0; st_f1 = '0; st_f2 = '0; st_b = '0;

        // Reset with live inputs
        vec(0,1,0,0, 5,6, 'h11,'h22, 5,6,9, 3'b111,3'b111, 'hA,'hB,'hC, 0, 0,0,0,0,0);
        vec(0,1,0,0, 5,6, 'h11,'h22, 5,6,9, 3'b111,3'b111, 'hA,'hB,'hC, 0, 0,0,0,0,0);
        // No match -> RF
        vec(1,1,0,0, 5,3, 'h100,'h200, 7,8,9, 3'b111,3'b111, 1,2,3, 0, 1,'h100,'h200,0,0);
        // Youngest match wins; op1 hits source 2
        vec(1,1,0,0, 5,9, 'h300,'h400, 5,5,9, 3'b111,3'b111, 'hAAAA,'hBBBB,'hCCCC, 0, 1,'hAAAA,'hCCCC,1,3);
        vec(1,1,0,0, 5,9, 'h300,'h400, 5,5,9, 3'b110,3'b111, 'hAAAA,'hBBBB,'hCCCC, 0, 1,'hBBBB,'hCCCC,2,3);
        // Address 0 never forwards, never hazards
        vec(1,1,0,0, 0,0, 0,0, 0,0,0, 3'b111,3'b000, 'hDEAD,'hBEEF,'hF00D, 0, 1,0,0,0,0);
        // Load-use bubble then capture
        vec(1,1,0,0, 4,2, 'h40,'h20, 4,2,0, 3'b011,3'b010, 0,'h55,0, 1, 0,0,0,0,0);
        expect_stats(2, 2, 2, 1);
        vec(1,1,0,0, 4,2, 'h40,'h20, 4,2,0, 3'b011,3'b011, 'h1234,'h55,0, 0, 1,'h1234,'h55,1,2);
        // Youngest not ready, older ready with same address: still a bubble
        vec(1,1,0,0, 3,8, 'h30,'h80, 8,8,0, 3'b011,3'b010, 1,2,0, 1, 0,0,0,0,0);
        // Known state, then 3 stall cycles with changing inputs
        vec(1,1,0,0, 1,2, 'h77,'h88, 1,2,0, 3'b000,3'b111, 9,9,9, 0, 1,'h77,'h88,0,0);
        vec(1,1,1,0, 5,6, 1,2, 5,6,0, 3'b111,3'b111, 3,4,5, 0, 1,'h77,'h88,0,0);
        vec(1,1,1,0, 7,0, 6,7, 7,0,0, 3'b001,3'b000, 8,0,0, 1, 1,'h77,'h88,0,0);
        vec(1,0,1,0, 1,2, 9,'hA, 1,2,0, 3'b011,3'b011, 'hB,'hC,0, 0, 1,'h77,'h88,0,0);
        // Flush beats stall
        vec(1,1,1,1, 1,2, 9,'hA, 0,0,0, 3'b000,3'b111, 0,0,0, 0, 0,0,0,0,0);
        vec(1,1,0,0, 7,2, 'h70,'h20, 7,0,0, 3'b001,3'b001, 'h99,0,0, 0, 1,'h99,'h20,1,0);
        // Flush with hazard: flush result, hazard still visible
        vec(1,1,0,1, 7,2, 'h70,'h20, 7,0,0, 3'b001,3'b000, 'h99,0,0, 1, 0,0,0,0,0);
        // valid_i=0 still captures data
        expect_stats(3, 2, 2, 2);
        vec(1,0,0,0, 1,3, 5,6, 0,0,0, 3'b000,3'b111, 0,0,0, 0, 0,5,6,0,0);
        // Reset during stall clears everything
        expect_stats(0, 0, 0, 0);
        vec(0,1,1,0, 1,3, 5,6, 1,0,0, 3'b001,3'b111, 'hE,0,0, 0, 0,0,0,0,0);
        vec(1,1,0,0, 1,3, 5,6, 1,0,0, 3'b001,3'b111, 'hE,0,0, 0, 1,'hE,6,1,0);
        drv_done = 1'b1;
    end

    // Monitor
    initial begin
        exp_t e;
        bit   h;
        int   idle = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("valid_o", 96'(valid_o), 96'(e.v));
                chk("op_data_o", 96'(op_data_o), 96'(e.d));
                chk("sel_o", 96'(sel_o), 96'(e.s));
`ifdef FWD_STATS_EN
                if (e.st_chk) begin
                    chk("fwd_cnt_o", 96'(fwd_cnt_o), {e.f2, e.f1, e.f0});
                    chk("bubble_cnt_o", 96'(bubble_cnt_o), 96'(e.b));
                end
`endif
            end else if (drv_done) begin
                idle++;
                if (hq.size() == 0 || idle > 5) begin
                    if (hq.size() != 0) begin
                        total++;
                        $display("FAIL drain: %0d hazard entries left, expected 0", hq.size());
                    end
                    $display("%0d/%0d checks passed", passed, total);
                    $finish;
                end
            end
            @(negedge clk_i);
            #3;
            if (hq.size() > 0) begin
                h = hq.pop_front();
                chk("hazard_o", 96'(hazard_o), 96'(h));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
